// File: rtl/systolic_sequencer_pkg.sv
// matmul_pkg: shared declarations for the systolic matmul sequencer.
// Latency: none; this file holds types, constants and helpers only.
// Backpressure: none.
package matmul_pkg;

    // Default array edge; instances may override it through their parameters.
    localparam int ARRAY_DIM = 4;

    // Width of a dimension field able to hold 0..ARRAY_DIM.
    localparam int DIM_W = $clog2(ARRAY_DIM + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FEED,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Feed cycles: K elements per lane, plus the skew of the last row
    // (max_dim-1) and the hop of the last column (max_dim-1).
    function automatic int feed_len(input int k, input int max_dim);
        return k + 2 * max_dim - 2;
    endfunction

endpackage

// File: rtl/systolic_sequencer_if.sv
// systolic_sequencer_if: operand/command bus and PE-array drive bus of the sequencer.
// Latency: none; wires only.
// Backpressure: none; start is a one-cycle request, the sequencer ignores it while busy.
// master: operand/command side (drives start, dims, matrices; observes status and edges).
// slave : the sequencer (drives edge vectors, PE controls and status).
interface systolic_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_DIM    = 4
);
    localparam int DW = $clog2(MAX_DIM + 1);

    logic                                  start_i;
    logic [DW-1:0]                         dim_n_i;
    logic [DW-1:0]                         dim_k_i;
    logic [DW-1:0]                         dim_m_i;
    logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] mat_a_i;
    logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] mat_b_i;
    logic [MAX_DIM*DATA_WIDTH-1:0]         left_o;
    logic [MAX_DIM*DATA_WIDTH-1:0]         up_o;
    logic                                  pe_clr_o;
    logic                                  pe_en_o;
    logic                                  busy_o;
    logic                                  done_o;
    logic                                  err_o;

    modport master (
        output start_i, dim_n_i, dim_k_i, dim_m_i, mat_a_i, mat_b_i,
        input  left_o, up_o, pe_clr_o, pe_en_o, busy_o, done_o, err_o
    );

    modport slave (
        input  start_i, dim_n_i, dim_k_i, dim_m_i, mat_a_i, mat_b_i,
        output left_o, up_o, pe_clr_o, pe_en_o, busy_o, done_o, err_o
    );
endinterface

// File: rtl/systolic_skew_sel.sv
// systolic_skew_sel: picks the skewed, zero-padded edge element for every lane at step t.
// Latency: combinational.  Backpressure: none.
// Ports: i_step (t), i_lanes (N for A / M for B), i_dim_k (K), i_mat (packed row-major
// matrix), o_edge (MAX_DIM lanes of DATA_WIDTH). COL_MODE=0 reads A[l][t-l], 1 reads B[t-l][l].
module systolic_skew_sel
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_DIM    = 4,
    parameter int CNT_W      = 4,
    parameter int DW         = 3,
    parameter bit COL_MODE   = 1'b0
) (
    input  logic [CNT_W-1:0]                    i_step,
    input  logic [DW-1:0]                       i_lanes,
    input  logic [DW-1:0]                       i_dim_k,
    input  logic [MAX_DIM*MAX_DIM*DATA_WIDTH-1:0] i_mat,
    output logic [MAX_DIM*DATA_WIDTH-1:0]       o_edge
);
    int w_kk;
    int w_idx;

    always_comb begin
        o_edge = '0;
        w_kk   = 0;
        w_idx  = 0;
        for (int l = 0; l < MAX_DIM; l++) begin
            // Lane l lags lane 0 by l steps; kk is the inner-product index it carries now.
            w_kk  = int'(i_step) - l;
            w_idx = COL_MODE ? (w_kk * MAX_DIM + l) : (l * MAX_DIM + w_kk);
            if ((l < int'(i_lanes)) && (w_kk >= 0) && (w_kk < int'(i_dim_k))) begin
                o_edge[l*DATA_WIDTH +: DATA_WIDTH] = i_mat[w_idx*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end
endmodule

// File: rtl/systolic_sequencer.sv
// systolic_sequencer: sequences one A(NxK) x B(KxM) product through the MAX_DIM^2 PE array.
// Latency: start to done_o = K + 2*MAX_DIM + PIPE_LAT cycles; illegal dims give done_o+err_o next cycle.
// Backpressure: none; start_i is ignored while busy_o, operands are read live and must stay stable.
// Ports: clk_i, rst_ni (async, active-low), bus (slave modport: start/dims/matrices in,
// registered left/up edge vectors, pe_clr/pe_en, busy/done/err out).
module systolic_sequencer
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_DIM    = ARRAY_DIM,
    parameter int PIPE_LAT   = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    systolic_sequencer_if.slave bus
);
    localparam int DW      = $clog2(MAX_DIM + 1);
    localparam int CNT_MAX = (3 * MAX_DIM > PIPE_LAT) ? 3 * MAX_DIM : PIPE_LAT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int EW      = MAX_DIM * DATA_WIDTH;
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [DW-1:0]    r_n, r_k, r_m;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_feed_last;
    logic [EW-1:0]    r_left, r_up;
    logic [EW-1:0]    w_left, w_up;
    logic             w_dims_ok;
    logic             w_start;

    assign w_dims_ok = (bus.dim_n_i != '0) && (bus.dim_n_i <= DW'(MAX_DIM)) &&
                       (bus.dim_k_i != '0) && (bus.dim_k_i <= DW'(MAX_DIM)) &&
                       (bus.dim_m_i != '0) && (bus.dim_m_i <= DW'(MAX_DIM));
    assign w_start     = bus.start_i && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_feed_last = CNT_W'(feed_len(int'(r_k), MAX_DIM) - 1);

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start_i) w_state_nxt = w_dims_ok ? ST_CLEAR : ST_DONE;
                else             w_state_nxt = ST_IDLE;
            end
            ST_CLEAR: w_state_nxt = ST_FEED;
            ST_FEED: begin
                if (r_cnt == w_feed_last) w_state_nxt = (PIPE_LAT > 0) ? ST_DRAIN : ST_DONE;
            end
            ST_DRAIN: begin
                if (r_cnt == DRAIN_LAST) w_state_nxt = ST_DONE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode from the current state.
    always_comb begin
        bus.pe_clr_o = 1'b0;
        bus.pe_en_o  = 1'b0;
        bus.busy_o   = 1'b0;
        bus.done_o   = 1'b0;
        bus.err_o    = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                bus.pe_clr_o = 1'b1;
                bus.busy_o   = 1'b1;
            end
            ST_FEED, ST_DRAIN: begin
                bus.pe_en_o = 1'b1;
                bus.busy_o  = 1'b1;
            end
            ST_DONE: begin
                bus.done_o = 1'b1;
                bus.err_o  = r_err;
            end
            default: ;
        endcase
    end

    // Counter value for the next cycle: feed step while feeding, drain index while draining.
    // The skew selectors look at this next value so the registered edges line up with r_cnt.
    always_comb begin
        w_cnt_nxt = '0;
        if ((r_state == ST_FEED) && (r_cnt != w_feed_last)) w_cnt_nxt = r_cnt + CNT_W'(1);
        else if ((r_state == ST_DRAIN) && (r_cnt != DRAIN_LAST)) w_cnt_nxt = r_cnt + CNT_W'(1);
    end

    systolic_skew_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_DIM    (MAX_DIM),
        .CNT_W      (CNT_W),
        .DW         (DW),
        .COL_MODE   (1'b0)
    ) u_skew_a (
        .i_step  (w_cnt_nxt),
        .i_lanes (r_n),
        .i_dim_k (r_k),
        .i_mat   (bus.mat_a_i),
        .o_edge  (w_left)
    );

    systolic_skew_sel #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_DIM    (MAX_DIM),
        .CNT_W      (CNT_W),
        .DW         (DW),
        .COL_MODE   (1'b1)
    ) u_skew_b (
        .i_step  (w_cnt_nxt),
        .i_lanes (r_m),
        .i_dim_k (r_k),
        .i_mat   (bus.mat_b_i),
        .o_edge  (w_up)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_n    <= '0;
            r_k    <= '0;
            r_m    <= '0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
            r_left <= '0;
            r_up   <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_start) begin
                r_err <= !w_dims_ok;
                if (w_dims_ok) begin
                    r_n <= bus.dim_n_i;
                    r_k <= bus.dim_k_i;
                    r_m <= bus.dim_m_i;
                end
            end
            // Edges carry data only in FEED cycles; every other state presents zeros.
            r_left <= (w_state_nxt == ST_FEED) ? w_left : '0;
            r_up   <= (w_state_nxt == ST_FEED) ? w_up   : '0;
        end
    end

    assign bus.left_o = r_left;
    assign bus.up_o   = r_up;
endmodule

// File: tb/tb_systolic_sequencer.sv
module tb_systolic_sequencer;
    localparam int MD = 4;

    typedef struct packed {
        logic         busy;
        logic         clr;
        logic         en;
        logic         done;
        logic         err;
        logic         pe_chk;
        logic [127:0] left;
        logic [127:0] up;
        logic [511:0] c;
    } rec_t;

    typedef struct packed {
        logic [511:0] acc;
        logic [511:0] a;
        logic [511:0] b;
    } pe_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    rec_t q0[$];
    rec_t q1[$];
    pe_t  pe0, pe1;
    logic [511:0] a1, idm, c2, a6, b6, c6;
    logic [31:0]  l2_exp [7];

    always #5 clk = ~clk;

    systolic_sequencer_if #(.DATA_WIDTH(32), .MAX_DIM(MD)) sif0 ();
    systolic_sequencer_if #(.DATA_WIDTH(32), .MAX_DIM(MD)) sif1 ();

    systolic_sequencer #(.DATA_WIDTH(32), .MAX_DIM(MD), .PIPE_LAT(1)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .bus(sif0)
    );
    systolic_sequencer #(.DATA_WIDTH(32), .MAX_DIM(MD), .PIPE_LAT(3)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(sif1)
    );

    // Behavioural PE array: operands enter at the edges and hop one PE per enabled cycle.
    function automatic pe_t pe_step(input pe_t s, input logic clr, input logic en,
                                    input logic [127:0] lf, input logic [127:0] upv);
        pe_t n;
        logic [31:0] ain, bin;
        n = s;
        if (clr) n = '0;
        else if (en) begin
            for (int i = 0; i < MD; i++) begin
                for (int j = 0; j < MD; j++) begin
                    ain = (j == 0) ? lf[i*32 +: 32]  : s.a[(i*MD + j - 1)*32 +: 32];
                    bin = (i == 0) ? upv[j*32 +: 32] : s.b[((i - 1)*MD + j)*32 +: 32];
                    n.acc[(i*MD + j)*32 +: 32] = s.acc[(i*MD + j)*32 +: 32] + ain * bin;
                    n.a[(i*MD + j)*32 +: 32] = ain;
                    n.b[(i*MD + j)*32 +: 32] = bin;
                end
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin
        pe0 <= pe_step(pe0, sif0.pe_clr_o, sif0.pe_en_o, sif0.left_o, sif0.up_o);
        pe1 <= pe_step(pe1, sif1.pe_clr_o, sif1.pe_en_o, sif1.left_o, sif1.up_o);
    end

    function automatic logic [31:0] elem(input logic [511:0] mat, input int lane, input int kk,
                                         input int lanes, input int k, input bit col);
        if (lane >= lanes || kk < 0 || kk >= k) return 32'd0;
        return col ? mat[(kk*MD + lane)*32 +: 32] : mat[(lane*MD + kk)*32 +: 32];
    endfunction

    task automatic push(input int inst, input rec_t r);
        if (inst == 0) q0.push_back(r);
        else           q1.push_back(r);
    endtask

    // Expected cycle-by-cycle trace of a legal operation, from cycle 1 to the done cycle.
    task automatic expect_run(input int inst, input int n, input int k, input int m, input int lat,
                              input logic [511:0] a, input logic [511:0] b, input logic [511:0] c);
        rec_t r;
        int   f;
        f = k + 2*MD - 2;
        for (int cy = 1; cy <= f + 2 + lat; cy++) begin
            r = '0;
            if (cy == 1) begin
                r.busy = 1'b1; r.clr = 1'b1;
            end else if (cy <= f + 1) begin
                r.busy = 1'b1; r.en = 1'b1;
                for (int l = 0; l < MD; l++) begin
                    r.left[l*32 +: 32] = elem(a, l, cy - 2 - l, n, k, 1'b0);
                    r.up[l*32 +: 32]   = elem(b, l, cy - 2 - l, m, k, 1'b1);
                end
            end else if (cy <= f + 1 + lat) begin
                r.busy = 1'b1; r.en = 1'b1;
            end else begin
                r.done = 1'b1; r.pe_chk = 1'b1; r.c = c;
            end
            push(inst, r);
        end
    endtask

    task automatic expect_err(input int inst);
        rec_t r;
        r = '0;
        r.done = 1'b1;
        r.err  = 1'b1;
        push(inst, r);
    endtask

    // Monitor: one expected record per cycle while a trace is queued, otherwise all-quiet outputs.
    task automatic mon(input int inst, input logic [4:0] ctl, input logic [127:0] lf,
                       input logic [127:0] upv, input logic [511:0] acc);
        rec_t e;
        e = '0;
        if (inst == 0 && q0.size() > 0)      e = q0.pop_front();
        else if (inst == 1 && q1.size() > 0) e = q1.pop_front();
        checks++;
        if (ctl !== {e.busy, e.clr, e.en, e.done, e.err} || lf !== e.left || upv !== e.up) begin
            errors++;
            $display("FAIL u%0d trace @%0t: busy/clr/en/done/err=%b left=%h up=%h, required %b left=%h up=%h",
                     inst, $time, ctl, lf, upv, {e.busy, e.clr, e.en, e.done, e.err}, e.left, e.up);
        end
        if (e.pe_chk) begin
            checks++;
            if (acc !== e.c) begin
                errors++;
                $display("FAIL u%0d pe_result @%0t: got %h required %h", inst, $time, acc, e.c);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, {sif0.busy_o, sif0.pe_clr_o, sif0.pe_en_o, sif0.done_o, sif0.err_o},
            sif0.left_o, sif0.up_o, pe0.acc);
        mon(1, {sif1.busy_o, sif1.pe_clr_o, sif1.pe_en_o, sif1.done_o, sif1.err_o},
            sif1.left_o, sif1.up_o, pe1.acc);
    end

    // Called from a negedge; the start is sampled at the following posedge (edge 0).
    task automatic start_op(input int inst, input int n, input int k, input int m,
                            input logic [511:0] a, input logic [511:0] b);
        sif0.dim_n_i = 3'(n); sif0.dim_k_i = 3'(k); sif0.dim_m_i = 3'(m);
        sif1.dim_n_i = 3'(n); sif1.dim_k_i = 3'(k); sif1.dim_m_i = 3'(m);
        sif0.mat_a_i = a; sif0.mat_b_i = b;
        sif1.mat_a_i = a; sif1.mat_b_i = b;
        if (inst == 0) sif0.start_i = 1'b1;
        else           sif1.start_i = 1'b1;
        @(posedge clk);
        #1;
        sif0.start_i = 1'b0;
        sif1.start_i = 1'b0;
    endtask

    task automatic wait_done(input int inst);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = (inst == 0) ? sif0.done_o : sif1.done_o;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL u%0d done_timeout: done_o not seen in 100 cycles, required one pulse", inst);
        end
    endtask

    initial begin
        a1 = '0; idm = '0; c2 = '0; c6 = '0;
        for (int i = 0; i < 16; i++) a1[i*32 +: 32] = 32'(i + 1);
        for (int r = 0; r < MD; r++) idm[(r*5)*32 +: 32] = 32'd1;
        // 2x3 * 3x2 with both operands taken from a1: [1 2 3;5 6 7] * [1 2;5 6;9 10]
        c2[0*32 +: 32] = 32'd38;  c2[1*32 +: 32] = 32'd44;
        c2[4*32 +: 32] = 32'd98;  c2[5*32 +: 32] = 32'd116;
        a6 = a1;  a6[31:0] = 32'd7;
        b6 = a1;  b6[31:0] = 32'd6;
        c6[31:0] = 32'd42;
        l2_exp[0] = 32'd0;  l2_exp[1] = 32'd0;  l2_exp[2] = 32'd9;  l2_exp[3] = 32'd10;
        l2_exp[4] = 32'd11; l2_exp[5] = 32'd12; l2_exp[6] = 32'd0;

        rst_n = 1'b0;
        sif0.start_i = 1'b0; sif1.start_i = 1'b0;
        sif0.dim_n_i = '0; sif0.dim_k_i = '0; sif0.dim_m_i = '0;
        sif1.dim_n_i = '0; sif1.dim_k_i = '0; sif1.dim_m_i = '0;
        sif0.mat_a_i = '0; sif0.mat_b_i = '0; sif1.mat_a_i = '0; sif1.mat_b_i = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 4x4x4, A * I: done in cycle 13, left lane 2 carries row 2 delayed by two steps.
        start_op(0, 4, 4, 4, a1, idm);
        expect_run(0, 4, 4, 4, 1, a1, idm, a1);
        @(negedge clk);
        for (int s = 0; s < 7; s++) begin
            @(negedge clk);
            checks++;
            if (sif0.left_o[95:64] !== l2_exp[s]) begin
                errors++;
                $display("FAIL left2_t%0d: got %0d required %0d", s, sif0.left_o[95:64], l2_exp[s]);
            end
        end
        wait_done(0);
        repeat (2) @(negedge clk);

        // 2x3x2: lanes 2,3 stay zero, F=9, done in cycle 12.
        start_op(0, 2, 3, 2, a1, a1);
        expect_run(0, 2, 3, 2, 1, a1, a1, c2);
        wait_done(0);
        repeat (2) @(negedge clk);

        // Illegal dimensions: immediate done+err, no PE activity.
        start_op(0, 4, 0, 4, a1, idm);
        expect_err(0);
        wait_done(0);
        repeat (2) @(negedge clk);
        start_op(0, 5, 4, 4, a1, idm);
        expect_err(0);
        wait_done(0);
        repeat (2) @(negedge clk);

        // Starts during a run are ignored; a start in the DONE cycle chains with no gap.
        start_op(0, 4, 4, 4, a1, idm);
        expect_run(0, 4, 4, 4, 1, a1, idm, a1);
        repeat (3) @(posedge clk);
        #1 sif0.start_i = 1'b1;
        @(posedge clk);
        #1 sif0.start_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 sif0.start_i = 1'b1;
        @(posedge clk);
        #1 sif0.start_i = 1'b0;
        wait_done(0);
        start_op(0, 4, 4, 4, idm, a1);
        expect_run(0, 4, 4, 4, 1, idm, a1, a1);
        wait_done(0);
        repeat (2) @(negedge clk);

        // Reset in the middle of FEED: everything drops at once, no done_o.
        start_op(0, 4, 4, 4, a1, idm);
        expect_run(0, 4, 4, 4, 1, a1, idm, a1);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        checks++;
        if ({sif0.busy_o, sif0.pe_clr_o, sif0.pe_en_o, sif0.done_o, sif0.err_o,
             sif0.left_o, sif0.up_o} !== '0) begin
            errors++;
            $display("FAIL reset_abort: busy/clr/en/done/err=%b left=%h up=%h, required all zero",
                     {sif0.busy_o, sif0.pe_clr_o, sif0.pe_en_o, sif0.done_o, sif0.err_o},
                     sif0.left_o, sif0.up_o);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_op(0, 2, 3, 2, a1, a1);
        expect_run(0, 2, 3, 2, 1, a1, a1, c2);
        wait_done(0);
        repeat (2) @(negedge clk);

        // PIPE_LAT=3, 1x1x1, 7*6: F=7, done in cycle 12.
        start_op(1, 1, 1, 1, a6, b6);
        expect_run(1, 1, 1, 1, 3, a6, b6, c6);
        wait_done(1);
        repeat (3) @(negedge clk);

        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d/%0d expected records unconsumed, required 0/0",
                     q0.size(), q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
